// File: rtl/id_exe_hazard_reg.sv
// ---------------------------------------------------------------------------
// id_exe_hazard_reg
//   ID->EXE pipeline register with RAW hazard detection and a stall watchdog.
//   It sits directly upstream of the forwarding unit.
//   - With forwarding on, only load-use hazards stall: a load in EXE whose
//     destination is read by ID.
//   - With forwarding off, every RAW hazard against EXE or MEM stalls.
//   - A stall holds PC and IF/ID (hazard_stall) and loads a bubble into EXE.
//
// Configuration macro: STALL_COUNTER_EN
//   Defined   : adds the bubble_cnt output, which counts bubbles inserted by
//               hazard stalls. The counter wraps modulo 2^CNT_W.
//   Undefined : no bubble_cnt port and no counter logic.
//
// Ports
//   clk, rst                 clock (rising edge) and async active-high reset
//   enable_forward_unit      1 = forwarding active, 0 = stall on every RAW hazard
//   freeze                   global hold; all state holds
//   flush                    squash the ID instruction (bubble)
//   id_*                     ID-stage instruction fields
//   mem_reg_dest, mem_wb_en  MEM-stage destination and write-back enable
//   hazard_stall             combinational stall request to PC and IF/ID
//   exe_*                    registered instruction fields for EXE and forwarding
//   stall_err                sticky flag: STALL_LIMIT consecutive stall cycles
//   bubble_cnt               total hazard bubbles (STALL_COUNTER_EN only)
// ---------------------------------------------------------------------------
module id_exe_hazard_reg #(
    parameter int REG_W       = 5,
    parameter int STALL_LIMIT = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_forward_unit,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] id_reg_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_is_bne,
    input  logic [REG_W-1:0] mem_reg_dest,
    input  logic             mem_wb_en,
    output logic             hazard_stall,
    output logic             exe_valid,
    output logic [REG_W-1:0] exe_src1,
    output logic [REG_W-1:0] exe_src2,
    output logic [REG_W-1:0] exe_reg_dest,
    output logic             exe_wb_en,
    output logic             exe_mem_read,
    output logic             exe_mem_write,
    output logic             exe_is_bne,
    output logic             exe_is_store,
`ifdef STALL_COUNTER_EN
    output logic [CNT_W-1:0] bubble_cnt,
`endif
    output logic             stall_err
);

    localparam int RUN_W = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);

    if (STALL_LIMIT < 1 || CNT_W < 1) begin : g_bad_param
        $error("id_exe_hazard_reg: STALL_LIMIT and CNT_W must be >= 1");
    end

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
        logic             mem_write;
        logic             is_bne;
        logic             is_store;
    } exe_t;

    exe_t             exe_q, exe_d;
    logic [RUN_W-1:0] stall_run_q, stall_run_d;
    logic             stall_err_q, stall_err_d;
    logic             exe_match, mem_match, hazard;

    // Register 0 is hardwired, so it never matches. src2 only counts when it is a real read.
    always_comb begin
        exe_match = 1'b0;
        mem_match = 1'b0;
        if (id_src1 != '0 && id_src1 == exe_q.dest)
            exe_match = 1'b1;
        if (id_two_src && id_src2 != '0 && id_src2 == exe_q.dest)
            exe_match = 1'b1;
        if (id_src1 != '0 && id_src1 == mem_reg_dest)
            mem_match = 1'b1;
        if (id_two_src && id_src2 != '0 && id_src2 == mem_reg_dest)
            mem_match = 1'b1;
    end

    always_comb begin
        if (enable_forward_unit)
            hazard = exe_q.valid & exe_q.mem_read & exe_q.wb_en & exe_match;
        else
            hazard = (exe_q.valid & exe_q.wb_en & exe_match) | (mem_wb_en & mem_match);
    end

    assign hazard_stall = id_valid & hazard & ~flush & ~freeze;

    always_comb begin
        exe_d       = exe_q;
        stall_run_d = stall_run_q;
        stall_err_d = stall_err_q;
        if (!freeze) begin
            if (flush || hazard_stall || !id_valid) begin
                exe_d = '0;
            end else begin
                exe_d.valid     = 1'b1;
                exe_d.src1      = id_src1;
                exe_d.src2      = id_src2;
                exe_d.dest      = id_reg_dest;
                exe_d.wb_en     = id_wb_en;
                exe_d.mem_read  = id_mem_read;
                exe_d.mem_write = id_mem_write;
                exe_d.is_bne    = id_is_bne;
                exe_d.is_store  = id_mem_write;
            end
            // The run length saturates so the watchdog cannot wrap back to zero.
            if (!hazard_stall)
                stall_run_d = '0;
            else if (stall_run_q != RUN_MAX)
                stall_run_d = stall_run_q + 1'b1;
            if (stall_run_d == RUN_MAX)
                stall_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q       <= '0;
            stall_run_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            exe_q       <= exe_d;
            stall_run_q <= stall_run_d;
            stall_err_q <= stall_err_d;
        end
    end

`ifdef STALL_COUNTER_EN
    // Counts only bubbles caused by hazard stalls. Flush and idle bubbles are excluded.
    // hazard_stall is already zero while frozen.
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (hazard_stall)
            bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt_q <= '0;
        else
            bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

    assign exe_valid     = exe_q.valid;
    assign exe_src1      = exe_q.src1;
    assign exe_src2      = exe_q.src2;
    assign exe_reg_dest  = exe_q.dest;
    assign exe_wb_en     = exe_q.wb_en;
    assign exe_mem_read  = exe_q.mem_read;
    assign exe_mem_write = exe_q.mem_write;
    assign exe_is_bne    = exe_q.is_bne;
    assign exe_is_store  = exe_q.is_store;
    assign stall_err     = stall_err_q;

endmodule

// File: tb/tb_id_exe_hazard_reg.sv
module tb_id_exe_hazard_reg;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fwd = 1'b1, freeze = 1'b0, flush = 1'b0;
    logic       id_valid = 1'b0, id_two_src = 1'b0;
    logic [4:0] id_src1 = '0, id_src2 = '0, id_reg_dest = '0, mem_reg_dest = '0;
    logic       id_wb_en = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0, id_is_bne = 1'b0;
    logic       mem_wb_en = 1'b0;

    logic       hazard_stall, exe_valid, exe_wb_en, exe_mem_read, exe_mem_write;
    logic       exe_is_bne, exe_is_store, stall_err;
    logic [4:0] exe_src1, exe_src2, exe_reg_dest;
`ifdef STALL_COUNTER_EN
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    id_exe_hazard_reg #(.REG_W(5), .STALL_LIMIT(LIMIT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .enable_forward_unit(fwd), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_reg_dest(id_reg_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_is_bne(id_is_bne),
        .mem_reg_dest(mem_reg_dest), .mem_wb_en(mem_wb_en),
        .hazard_stall(hazard_stall), .exe_valid(exe_valid), .exe_src1(exe_src1),
        .exe_src2(exe_src2), .exe_reg_dest(exe_reg_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write),
        .exe_is_bne(exe_is_bne), .exe_is_store(exe_is_store),
`ifdef STALL_COUNTER_EN
        .bubble_cnt(bubble_cnt),
`endif
        .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    // Model of what EXE holds: the instruction last accepted, or nothing.
    bit         m_valid, m_wb, m_mr, m_mw, m_bne;
    logic [4:0] m_s1, m_s2, m_dest;
    int         m_run;
    bit         m_err;
    int unsigned m_bub;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit id_reads(input logic [4:0] r);
        return (r != 0) && ((id_src1 == r) || (id_two_src && id_src2 == r));
    endfunction

    function automatic bit model_stall();
        bit blocked;
        if (fwd)
            blocked = m_valid && m_mr && m_wb && id_reads(m_dest);
        else
            blocked = (m_valid && m_wb && id_reads(m_dest)) || (mem_wb_en && id_reads(mem_reg_dest));
        return id_valid && blocked && !flush && !freeze;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_bne = 0;
        m_s1 = 0; m_s2 = 0; m_dest = 0; m_run = 0; m_err = 0; m_bub = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_valid"}, 32'(exe_valid), 32'(m_valid));
        chk({tag, "_src1"}, 32'(exe_src1), 32'(m_s1));
        chk({tag, "_src2"}, 32'(exe_src2), 32'(m_s2));
        chk({tag, "_dest"}, 32'(exe_reg_dest), 32'(m_dest));
        chk({tag, "_wb"}, 32'(exe_wb_en), 32'(m_wb));
        chk({tag, "_mr"}, 32'(exe_mem_read), 32'(m_mr));
        chk({tag, "_mw"}, 32'(exe_mem_write), 32'(m_mw));
        chk({tag, "_bne"}, 32'(exe_is_bne), 32'(m_bne));
        chk({tag, "_store"}, 32'(exe_is_store), 32'(m_mw));
        chk({tag, "_err"}, 32'(stall_err), 32'(m_err));
`ifdef STALL_COUNTER_EN
        chk({tag, "_bubcnt"}, bubble_cnt, m_bub);
`endif
    endtask

    task automatic set_id(input bit v, input int s1, input int s2, input bit two, input int d,
                          input bit wb, input bit mr, input bit mw, input bit bne);
        id_valid = v; id_src1 = 5'(s1); id_src2 = 5'(s2); id_two_src = two;
        id_reg_dest = 5'(d); id_wb_en = wb; id_mem_read = mr; id_mem_write = mw; id_is_bne = bne;
    endtask

    // One cycle: inputs are already applied; check at the falling edge, then step the model.
    // exp_hs >= 0 additionally pins hazard_stall to a hand-computed literal.
    task automatic cycle(input int exp_hs);
        bit hs;
        @(negedge clk);
        hs = model_stall();
        chk("hazard_stall", 32'(hazard_stall), 32'(hs));
        if (exp_hs >= 0) chk("hazard_stall_lit", 32'(hazard_stall), 32'(exp_hs));
        check_regs("cyc");
        @(posedge clk);
        if (!freeze) begin
            if (flush || hs || !id_valid) begin
                m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_bne = 0; m_s1 = 0; m_s2 = 0; m_dest = 0;
            end else begin
                m_valid = 1; m_s1 = id_src1; m_s2 = id_src2; m_dest = id_reg_dest;
                m_wb = id_wb_en; m_mr = id_mem_read; m_mw = id_mem_write; m_bne = id_is_bne;
            end
            m_run = hs ? ((m_run < LIMIT) ? m_run + 1 : LIMIT) : 0;
            if (m_run == LIMIT) m_err = 1;
            if (hs) m_bub++;
        end
        #1;
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(exe_valid), 32'd0);
        chk("rst_dest", 32'(exe_reg_dest), 32'd0);
        chk("rst_err", 32'(stall_err), 32'd0);
        check_regs("rst");
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_regs("por");
        @(posedge clk); #1 rst = 1'b0;

        // 1: forwarding on, load-use costs exactly one bubble.
        fwd = 1; mem_wb_en = 0;
        set_id(1, 1, 2, 0, 3, 1, 1, 0, 0);          // lw r3
        cycle(0);
        set_id(1, 3, 5, 1, 4, 1, 0, 0, 0);          // add r4,r3,r5
        cycle(1);
        chk("t1_bubble_valid", 32'(exe_valid), 32'd0);
        cycle(0);
        chk("t1_add_dest", 32'(exe_reg_dest), 32'd4);
        chk("t1_add_valid", 32'(exe_valid), 32'd1);

        // 2: forwarding off, stall on the EXE match, then on the MEM match.
        fwd = 0; set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(-1);
        set_id(1, 1, 2, 1, 3, 1, 0, 0, 0);          // add r3
        cycle(0);
        set_id(1, 3, 1, 1, 6, 1, 0, 0, 0);          // sub r6,r3,r1
        cycle(1);
        mem_wb_en = 1; mem_reg_dest = 3;
        cycle(1);
        mem_wb_en = 0;
        cycle(0);
        chk("t2_sub_dest", 32'(exe_reg_dest), 32'd6);

        // 3: r0 never hazards; a single-source instruction ignores src2.
        fwd = 1;
        set_id(1, 1, 1, 0, 0, 1, 1, 0, 0); cycle(-1);   // lw r0
        set_id(1, 0, 0, 1, 7, 1, 0, 0, 0); cycle(0);
        set_id(1, 1, 1, 0, 3, 1, 1, 0, 0); cycle(-1);   // lw r3
        set_id(1, 1, 3, 0, 8, 1, 0, 0, 0); cycle(0);    // addi r8,r1 (src2 field = r3)

        // 4: hazard and flush together: flush wins, no stall, bubble loaded.
        set_id(1, 1, 1, 0, 3, 1, 1, 0, 0); cycle(-1);
        set_id(1, 3, 3, 1, 9, 1, 0, 0, 0); flush = 1;
        cycle(0);
        flush = 0;
        chk("t4_flush_bubble", 32'(exe_valid), 32'd0);

        // 5: freeze over a pending load-use stall holds everything.
        set_id(1, 1, 1, 0, 3, 1, 1, 0, 0); cycle(-1);
        set_id(1, 3, 2, 1, 10, 1, 0, 0, 0); freeze = 1;
        repeat (3) cycle(0);
        chk("t5_frozen_dest", 32'(exe_reg_dest), 32'd3);
        freeze = 0;
        cycle(1);
        cycle(0);
        chk("t5_resume_dest", 32'(exe_reg_dest), 32'd10);

        // 6: a persistent MEM hazard trips the watchdog; then async reset mid-cycle.
        fwd = 0; mem_wb_en = 1; mem_reg_dest = 3;
        set_id(1, 3, 0, 0, 11, 1, 0, 0, 0);
        repeat (3) cycle(1);
        chk("t6_err_before", 32'(stall_err), 32'd0);
        cycle(1);
        chk("t6_err_set", 32'(stall_err), 32'd1);
        mem_wb_en = 0;
        cycle(0);
        chk("t6_err_sticky", 32'(stall_err), 32'd1);
        mem_wb_en = 1;
        cycle(1);
        async_reset();
        mem_wb_en = 0;
        cycle(0);
        chk("t6_post_rst_dest", 32'(exe_reg_dest), 32'd11);

        // Random traffic with a small register range to force collisions.
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) fwd = 1'($urandom_range(0, 1));
            set_id($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_reg_dest = 5'($urandom_range(0, 3));
            freeze       = ($urandom_range(0, 9) == 0);
            flush        = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 199) == 0) async_reset();
            cycle(-1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
